reg_file_checker: RTL and testbench

REG_FILE_CHECKER -- requirements
Module: reg_file_checker

---
 rtl/reg_file_checker.sv | 210 +++++++++++++++++++++
 tb/tb_reg_file_checker.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_checker.sv
// reg_file_checker: waits for halt (or timeout), then scans the register
// file and compares each value against an expected value.
//
// Ports:
//   clock, reset        - clock, async active-low reset
//   start, halt         - run request pulse, core-finished flag
//   care_mask           - per-register compare enable, captured on start
//   rf_rd_en/_index     - register file read request
//   rf_rd_data/exp_data - actual/expected values, valid one cycle after read
//   busy, done, passed, timed_out, fail_count,
//   first_fail_valid, first_fail_index - run status and results
// Optional feature (macro REG_FILE_CHECKER_LOG_EN):
//   log_valid/log_ready/log_index/log_expected/log_actual - mismatch log
//   stream; reads are throttled so that a pending record stalls the scan.

module reg_file_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REGS       = 32,
  parameter int INDEX_BITS     = 5,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int TIMEOUT_FAILS  = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt,
  input  logic [NUM_REGS-1:0]   care_mask,
  output logic                  rf_rd_en,
  output logic [INDEX_BITS-1:0] rf_rd_index,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic [DATA_WIDTH-1:0] exp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  passed,
  output logic                  timed_out,
  output logic [INDEX_BITS:0]   fail_count,
  output logic                  first_fail_valid,
  output logic [INDEX_BITS-1:0] first_fail_index
`ifdef REG_FILE_CHECKER_LOG_EN
  ,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [INDEX_BITS-1:0] log_index,
  output logic [DATA_WIDTH-1:0] log_expected,
  output logic [DATA_WIDTH-1:0] log_actual
`endif
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYCLES - 1);

  localparam logic [INDEX_BITS:0] PTR_END =
    (INDEX_BITS+1)'(NUM_REGS);

  localparam logic [INDEX_BITS-1:0] IDX_LAST =
    INDEX_BITS'(NUM_REGS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_SCAN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]            state;
  logic [CW-1:0]         wait_cnt;
  logic [NUM_REGS-1:0]   mask_q;
  logic [INDEX_BITS:0]   rd_ptr;
  logic                  cmp_pending;
  logic [INDEX_BITS-1:0] cmp_index;

  logic                  cmp_hit;
  logic                  last_cmp;
  logic                  issue_ok;
  logic [INDEX_BITS:0]   fail_count_nx;
  logic                  pass_nx;
  logic                  to_fail;

  assign busy = (state == S_WAIT) ||
                (state == S_SCAN);
  assign done = (state == S_DONE);

  assign cmp_hit = cmp_pending &&
                   mask_q[cmp_index] &&
                   (rf_rd_data != exp_data);

  assign last_cmp = cmp_pending &&
                    (cmp_index == IDX_LAST);

  assign fail_count_nx =
    fail_count + {{INDEX_BITS{1'b0}}, cmp_hit};

  assign to_fail = (TIMEOUT_FAILS != 0) && timed_out;

  assign pass_nx = (fail_count_nx == '0) && !to_fail;

`ifdef REG_FILE_CHECKER_LOG_EN
  logic scan_cmp_done;

  // A read may only start once the previous compare has retired and
  // no log record is waiting, so a mismatch can never be lost.
  assign issue_ok = !rf_rd_en && !cmp_pending &&
                    !log_valid &&
                    (rd_ptr != PTR_END);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      log_valid    <= 1'b0;
      log_index    <= '0;
      log_expected <= '0;
      log_actual   <= '0;
    end else if (log_valid && log_ready) begin
      log_valid <= 1'b0;
    end else if (cmp_hit) begin
      log_valid    <= 1'b1;
      log_index    <= cmp_index;
      log_expected <= exp_data;
      log_actual   <= rf_rd_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cmp_done <= 1'b0;
    end else if (state != S_SCAN) begin
      scan_cmp_done <= 1'b0;
    end else if (last_cmp) begin
      scan_cmp_done <= 1'b1;
    end
  end
`else
  assign issue_ok = (rd_ptr != PTR_END);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= S_IDLE;
      wait_cnt         <= '0;
      mask_q           <= '0;
      rd_ptr           <= '0;
      cmp_pending      <= 1'b0;
      cmp_index        <= '0;
      rf_rd_en         <= 1'b0;
      rf_rd_index      <= '0;
      passed           <= 1'b0;
      timed_out        <= 1'b0;
      fail_count       <= '0;
      first_fail_valid <= 1'b0;
      first_fail_index <= '0;
    end else begin
      cmp_pending <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state            <= S_WAIT;
            wait_cnt         <= '0;
            mask_q           <= care_mask;
            rd_ptr           <= '0;
            passed           <= 1'b0;
            timed_out        <= 1'b0;
            fail_count       <= '0;
            first_fail_valid <= 1'b0;
            first_fail_index <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          // halt has priority over a simultaneous timeout
          if (halt || (wait_cnt == CNT_LAST)) begin
            state       <= S_SCAN;
            timed_out   <= !halt;
            rf_rd_en    <= 1'b1;
            rf_rd_index <= '0;
            rd_ptr      <= {{INDEX_BITS{1'b0}}, 1'b1};
          end
        end
        S_SCAN: begin
          rf_rd_en    <= issue_ok;
          cmp_pending <= rf_rd_en;
          cmp_index   <= rf_rd_index;
          if (issue_ok) begin
            rf_rd_index <= rd_ptr[INDEX_BITS-1:0];
            rd_ptr      <= rd_ptr + 1'b1;
          end
          if (cmp_hit) begin
            fail_count <= fail_count_nx;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_index <= cmp_index;
            end
          end
`ifdef REG_FILE_CHECKER_LOG_EN
          if (scan_cmp_done && !log_valid) begin
            state  <= S_DONE;
            passed <= pass_nx;
          end
`else
          if (last_cmp) begin
            state  <= S_DONE;
            passed <= pass_nx;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_checker.sv
// tb_reg_file_checker: directed and randomized runs of reg_file_checker
// against a behavioural result model; two instances cover TIMEOUT_FAILS.

`timescale 1ns/1ps

module tb_reg_file_checker;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int IB = 5;
  localparam int TC = 100;
  localparam int BUDGET = 3000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          halt  = 1'b0;
  logic [NR-1:0] care_mask = '1;
  logic [DW-1:0] rf_rd_data = '0;
  logic [DW-1:0] exp_data   = '0;

  logic          rf_rd_en, t_rd_en;
  logic [IB-1:0] rf_rd_index, t_rd_index;
  logic          busy, t_busy;
  logic          done, t_done;
  logic          passed, t_passed;
  logic          timed_out, t_timed_out;
  logic [IB:0]   fail_count, t_fail_count;
  logic          ffv, t_ffv;
  logic [IB-1:0] ffi, t_ffi;

`ifdef REG_FILE_CHECKER_LOG_EN
  logic          log_ready = 1'b0;
  logic          log_valid, t_log_valid;
  logic [IB-1:0] log_index, t_log_index;
  logic [DW-1:0] log_expected, t_log_expected;
  logic [DW-1:0] log_actual, t_log_actual;
`endif

  always #5 clock = ~clock;

  reg_file_checker #(
    .DATA_WIDTH(DW), .NUM_REGS(NR),
    .INDEX_BITS(IB), .TIMEOUT_CYCLES(TC),
    .TIMEOUT_FAILS(0)
  ) u_dut (
    .clock(clock), .reset(reset),
    .start(start), .halt(halt),
    .care_mask(care_mask),
    .rf_rd_en(rf_rd_en),
    .rf_rd_index(rf_rd_index),
    .rf_rd_data(rf_rd_data),
    .exp_data(exp_data),
    .busy(busy), .done(done),
    .passed(passed),
    .timed_out(timed_out),
    .fail_count(fail_count),
    .first_fail_valid(ffv),
    .first_fail_index(ffi)
`ifdef REG_FILE_CHECKER_LOG_EN
    ,
    .log_valid(log_valid),
    .log_ready(log_ready),
    .log_index(log_index),
    .log_expected(log_expected),
    .log_actual(log_actual)
`endif
  );

  reg_file_checker #(
    .DATA_WIDTH(DW), .NUM_REGS(NR),
    .INDEX_BITS(IB), .TIMEOUT_CYCLES(TC),
    .TIMEOUT_FAILS(1)
  ) u_tf (
    .clock(clock), .reset(reset),
    .start(start), .halt(halt),
    .care_mask(care_mask),
    .rf_rd_en(t_rd_en),
    .rf_rd_index(t_rd_index),
    .rf_rd_data(rf_rd_data),
    .exp_data(exp_data),
    .busy(t_busy), .done(t_done),
    .passed(t_passed),
    .timed_out(t_timed_out),
    .fail_count(t_fail_count),
    .first_fail_valid(t_ffv),
    .first_fail_index(t_ffi)
`ifdef REG_FILE_CHECKER_LOG_EN
    ,
    .log_valid(t_log_valid),
    .log_ready(log_ready),
    .log_index(t_log_index),
    .log_expected(t_log_expected),
    .log_actual(t_log_actual)
`endif
  );

  logic [DW-1:0] act_mem [NR];
  logic [DW-1:0] exp_mem [NR];

  // register file plus expected-value table: data one cycle after read
  always @(posedge clock) begin
    if (rf_rd_en) begin
      rf_rd_data <= act_mem[rf_rd_index];
      exp_data   <= exp_mem[rf_rd_index];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic mem_match();
    for (int i = 0; i < NR; i++) begin
      act_mem[i] = $urandom;
      exp_mem[i] = act_mem[i];
    end
  endtask

  task automatic run_check(input string name,
                           input int halt_at,
                           input bit poke);
    int  cyc, nidx, efc, effi, wait_len;
    int  done_at, accepted, lg_wait;
    bit  effv, eto, early_pass;
    int  lq[$];
    logic [IB-1:0] h_idx;
    logic [DW-1:0] h_exp, h_act;
    int  e_i;

    // reference outcome from the rules alone
    eto      = !(halt_at >= 0 && halt_at < TC);
    wait_len = eto ? TC : halt_at + 1;
    done_at  = wait_len + NR + 1;
    efc = 0; effv = 1'b0; effi = 0;
    for (int i = 0; i < NR; i++) begin
      if (care_mask[i] && act_mem[i] !== exp_mem[i]) begin
        if (!effv) begin
          effv = 1'b1;
          effi = i;
        end
        efc++;
        lq.push_back(i);
      end
    end

    @(negedge clock);
    start = 1'b1;
    halt  = 1'b0;
    @(negedge clock);
    start = 1'b0;
    cyc = 0; nidx = 0; accepted = 0;
    lg_wait = 0; early_pass = 1'b0;
    h_idx = '0; h_exp = '0; h_act = '0;
    chk({name, ".busy_start"}, busy, 1'b1);
    chk({name, ".done_clr"}, done, 1'b0);

    while (!done && cyc < BUDGET) begin
      halt  = (cyc == halt_at);
      start = poke && (cyc == 1 || cyc == wait_len + 10);
      early_pass |= passed | t_passed;
      if (rf_rd_en) begin
        chk({name, ".rd_idx"}, rf_rd_index, nidx[IB-1:0]);
        nidx++;
      end
`ifdef REG_FILE_CHECKER_LOG_EN
      if (log_valid) begin
        if (lg_wait == 0) begin
          e_i = (lq.size() > 0) ? lq[0] : 999;
          chk({name, ".log_idx"}, log_index, e_i);
          chk({name, ".log_exp"}, log_expected,
              exp_mem[log_index]);
          chk({name, ".log_act"}, log_actual,
              act_mem[log_index]);
          h_idx = log_index;
          h_exp = log_expected;
          h_act = log_actual;
        end else begin
          chk({name, ".log_hold"},
              {log_index, log_expected, log_actual},
              {h_idx, h_exp, h_act});
        end
        lg_wait++;
        log_ready = (lg_wait > 10);
        if (log_ready) begin
          if (lq.size() > 0) void'(lq.pop_front());
          lg_wait = 0;
          accepted++;
        end
      end else begin
        log_ready = 1'b0;
      end
`endif
      @(negedge clock);
      cyc++;
    end
    halt  = 1'b0;
    start = 1'b0;

    chk({name, ".done"}, done, 1'b1);
    chk({name, ".early_pass"}, early_pass, 1'b0);
    chk({name, ".reads"}, nidx, NR);
`ifdef REG_FILE_CHECKER_LOG_EN
    log_ready = 1'b0;
    chk({name, ".log_left"}, lq.size(), 0);
    chk({name, ".log_cnt"}, accepted, efc);
    chk({name, ".log_idle"}, log_valid, 1'b0);
`else
    chk({name, ".latency"}, cyc, done_at);
`endif
    chk({name, ".fail_count"}, fail_count, efc);
    chk({name, ".ffv"}, ffv, effv);
    chk({name, ".ffi"}, ffi, effi);
    chk({name, ".timed_out"}, timed_out, eto);
    chk({name, ".passed"}, passed, efc == 0);
    chk({name, ".passed_tf"}, t_passed,
        efc == 0 && !eto);
    chk({name, ".busy_end"}, busy, 1'b0);
    chk({name, ".rd_en_end"}, rf_rd_en, 1'b0);

    repeat (3) @(negedge clock);
    chk({name, ".hold"},
        {done, passed, fail_count, ffv, ffi},
        {1'b1, efc == 0, efc[IB:0], effv, effi[IB-1:0]});
  endtask

  initial begin
    int found, k, hat;
    logic [DW-1:0] b;

    // reset values while reset is held
    #2;
    chk("rst.status", {busy, done, passed, timed_out},
        4'b0000);
    chk("rst.results", {fail_count, ffv, ffi},
        '0);
    chk("rst.rd", {rf_rd_en, rf_rd_index}, '0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst.idle", {busy, done}, 2'b00);

    // all registers match, halt in wait cycle 20
    mem_match();
    care_mask = '1;
    run_check("all_match", 20, 1'b0);

    // two counted mismatches; start pokes while busy
    mem_match();
    act_mem[11] = 32'h0000_0000;
    exp_mem[11] = 32'h0000_1000;
    act_mem[16] = 32'h0000_1000;
    exp_mem[16] = 32'h0000_1001;
    run_check("two_fail", 4, 1'b1);

    // masked-out mismatch
    mem_match();
    act_mem[11] = 32'h0000_0000;
    exp_mem[11] = 32'h0000_1000;
    care_mask = '1;
    care_mask[11] = 1'b0;
    run_check("masked", 7, 1'b0);

    // no halt: timeout path
    mem_match();
    care_mask = '1;
    run_check("timeout", -1, 1'b0);

    // halt on the last wait cycle wins over timeout
    run_check("halt_last", TC - 1, 1'b0);

    // halt in the first wait cycle, every register wrong
    for (int i = 0; i < NR; i++)
      exp_mem[i] = ~act_mem[i];
    run_check("all_fail", 0, 1'b0);

    // three mismatches (log stream back-pressure in log builds)
    mem_match();
    exp_mem[4]  = act_mem[4] + 1;
    exp_mem[17] = act_mem[17] ^ 32'h8000_0000;
    exp_mem[30] = '0;
    act_mem[30] = 32'h1;
    run_check("log3", 2, 1'b0);

    // reset in the middle of the scan
    mem_match();
    exp_mem[3] = ~act_mem[3];
    care_mask = '1;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    halt  = 1'b1;
`ifdef REG_FILE_CHECKER_LOG_EN
    log_ready = 1'b1;
`endif
    found = 0;
    k = 0;
    while (!found && k < BUDGET) begin
      @(negedge clock);
      halt = 1'b0;
      k++;
      if (rf_rd_en && rf_rd_index == 7) found = 1;
    end
    chk("mid.reached7", found, 1);
    chk("mid.count_pre", fail_count, 1);
    reset = 1'b0;
    #1;
`ifdef REG_FILE_CHECKER_LOG_EN
    log_ready = 1'b0;
    chk("mid.log_rst", log_valid, 1'b0);
`endif
    chk("mid.rst_status", {busy, done, passed, rf_rd_en},
        4'b0000);
    chk("mid.rst_res", {fail_count, ffv, ffi, rf_rd_index},
        '0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("mid.idle", {busy, done}, 2'b00);
    exp_mem[3] = act_mem[3];
    run_check("fresh", 5, 1'b0);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      b = $urandom;
      for (int i = 0; i < NR; i++) begin
        act_mem[i] = $urandom;
        exp_mem[i] = act_mem[i];
        if ($urandom_range(0, 5) == 0)
          exp_mem[i] = act_mem[i] ^
                       (32'h1 << $urandom_range(0, 31));
      end
      care_mask = b;
      hat = (r == 5) ? -1 : int'($urandom_range(0, 60));
      run_check($sformatf("rnd%0d", r), hat, r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
